// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stage-hold vectors, the ERET
// exception code, controller states, and the stall priority encoder.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall vector bit order: {wb, mem_wb, ex_mem, id_ex, if_id, pc}
  localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
  localparam logic [5:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_MEM  = {NO_STOP, STOP, STOP, STOP, STOP, STOP};

  localparam logic [31:0] EXC_ERET = 32'h0000000e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  // The deepest requesting stage wins, since it freezes everything upstream of it.
  function automatic logic [5:0] stall_select(input logic id_req, input logic ex_req,
                                              input logic mem_req);
    if (mem_req)     return STALL_MEM;
    else if (ex_req) return STALL_EX;
    else if (id_req) return STALL_ID;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Consecutive-stall watchdog: counts back-to-back stalled cycles and raises a
// sticky flag once the run reaches the timeout.
module stall_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic timeout
);

  localparam logic [31:0] LIMIT = 32'(TIMEOUT);

  logic [31:0] run_cnt_q;
  logic        timeout_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if (!stalled) begin
      run_cnt_q <= '0;
    end else if (run_cnt_q < LIMIT) begin
      run_cnt_q <= run_cnt_q + 32'd1;
      if (run_cnt_q == LIMIT - 32'd1) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: combinational per-stage stall and
// flush generation, one-cycle flush state, stall statistics and watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned  STALL_TIMEOUT = 1024,
  parameter logic [31:0]  EXC_ENTRY     = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  ctrl_state_e state_q;
  logic        exc_taken;
  logic [31:0] stall_cnt_q;

  assign exc_taken = rst && (state_q == ST_RUN) && (excepttype_i != '0);

  // NOTE: every output gets a default before the branches, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = '0;
    if (exc_taken) begin
      flush  = 1'b1;
      new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_ENTRY;
    end else if (rst && state_q == ST_RUN) begin
      stall = stall_select(stallreq_from_id, stallreq_from_ex, stallreq_from_mem);
    end
  end

  // FLUSH always lasts one cycle; requests arriving during it are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= exc_taken ? ST_FLUSH : ST_RUN;
  end

  // Free-running statistic; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     stall_cnt_q <= '0;
    else if (stall != STALL_NONE) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cycles = stall_cnt_q;

  stall_watchdog #(
    .TIMEOUT (STALL_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stalled (stall != STALL_NONE),
    .timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations
// per cycle, a monitor pops and compares them on the falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_from_id = 1'b0;
  logic        stallreq_from_ex = 1'b0;
  logic        stallreq_from_mem = 1'b0;
  logic [31:0] excepttype_i = '0;
  logic [31:0] cp0_epc_i = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] cycles;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  pipe_ctrl #(
    .STALL_TIMEOUT (8),
    .EXC_ENTRY     (32'h00000020)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .excepttype_i      (excepttype_i),
    .cp0_epc_i         (cp0_epc_i),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_cycles      (stall_cycles),
    .stall_timeout     (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_out(input string name, input logic [5:0] s, input logic f,
                            input logic [31:0] pc, input logic [31:0] cyc, input logic to);
    exp_t e;
    e.name = name; e.stall = s; e.flush = f; e.new_pc = pc; e.cycles = cyc; e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input logic r, input logic id, input logic ex,
                      input logic mem, input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] s, input logic f, input logic [31:0] pc,
                      input logic [31:0] cyc, input logic to);
    @(posedge clk);
    #1;
    rst = r;
    stallreq_from_id = id; stallreq_from_ex = ex; stallreq_from_mem = mem;
    excepttype_i = exc; cp0_epc_i = epc;
    expect_out(name, s, f, pc, cyc, to);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "/stall"},   32'(stall),         32'(mon_e.stall));
        check({mon_e.name, "/flush"},   32'(flush),         32'(mon_e.flush));
        check({mon_e.name, "/new_pc"},  new_pc,             mon_e.new_pc);
        check({mon_e.name, "/cycles"},  stall_cycles,       mon_e.cycles);
        check({mon_e.name, "/timeout"}, 32'(stall_timeout), 32'(mon_e.timeout));
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : driver
    //          name         rst id ex mem exc          epc           stall  fl pc            cycles        to
    step("rst_a",       0, 0, 0, 1, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    step("rst_b",       0, 1, 1, 1, 32'h1,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    // ex stall for three cycles
    step("ex_1",        1, 0, 1, 0, 32'h0,       32'h0,        6'h0f, 0, 32'h0,        32'd0,        0);
    step("ex_2",        1, 0, 1, 0, 32'h0,       32'h0,        6'h0f, 0, 32'h0,        32'd1,        0);
    step("ex_3",        1, 0, 1, 0, 32'h0,       32'h0,        6'h0f, 0, 32'h0,        32'd2,        0);
    step("ex_done",     1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd3,        0);
    // priority
    step("id_mem",      1, 1, 0, 1, 32'h0,       32'h0,        6'h1f, 0, 32'h0,        32'd3,        0);
    step("id_only",     1, 1, 0, 0, 32'h0,       32'h0,        6'h07, 0, 32'h0,        32'd4,        0);
    step("ex_mem",      1, 0, 1, 1, 32'h0,       32'h0,        6'h1f, 0, 32'h0,        32'd5,        0);
    step("idle_1",      1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd6,        0);
    // generic exception overrides stall, FLUSH ignores everything
    step("exc_ex",      1, 0, 1, 0, 32'h1,       32'h0,        6'h00, 1, 32'h20,       32'd6,        0);
    step("flush_ign",   1, 1, 1, 1, 32'h1,       32'h0,        6'h00, 0, 32'h0,        32'd6,        0);
    step("post_flush",  1, 0, 1, 0, 32'h0,       32'h0,        6'h0f, 0, 32'h0,        32'd6,        0);
    step("idle_2",      1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd7,        0);
    // ERET redirects to EPC
    step("eret",        1, 0, 0, 1, 32'he,       32'h00400104, 6'h00, 1, 32'h00400104, 32'd7,        0);
    step("eret_flush",  1, 0, 0, 0, 32'h0,       32'h00400104, 6'h00, 0, 32'h0,        32'd7,        0);
    step("eret_idle",   1, 0, 0, 0, 32'h0,       32'h00400104, 6'h00, 0, 32'h0,        32'd7,        0);

    // watchdog run counter clears on a non-stalled cycle
    step("rst_wdc",     0, 0, 0, 1, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    for (int i = 0; i < 7; i++)
      step("wdc_a",     1, 0, 0, 1, 32'h0,       32'h0,        6'h1f, 0, 32'h0,        32'(i),       0);
    step("wdc_gap",     1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd7,        0);
    for (int i = 0; i < 7; i++)
      step("wdc_b",     1, 0, 0, 1, 32'h0,       32'h0,        6'h1f, 0, 32'h0,        32'(7 + i),   0);
    step("wdc_end",     1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd14,       0);

    // watchdog fires after the 8th consecutive stalled edge and sticks
    step("rst_wd",      0, 0, 0, 1, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    for (int i = 0; i < 10; i++)
      step("wd_run",    1, 0, 0, 1, 32'h0,       32'h0,        6'h1f, 0, 32'h0,        32'(i),       logic'(i >= 8));
    step("wd_stick_a",  1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd10,       1);
    step("wd_stick_b",  1, 1, 0, 0, 32'h0,       32'h0,        6'h07, 0, 32'h0,        32'd10,       1);

    // stall_cycles wrap, then reset during FLUSH and during a stall
    step("rst_wrap",    0, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0; stallreq_from_mem = 1'b1;
    excepttype_i = '0; cp0_epc_i = '0;
    force dut.stall_cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.stall_cnt_q;
    expect_out("wrap_a", 6'h1f, 0, 32'h0, 32'hFFFFFFFE, 0);
    step("wrap_b",      1, 0, 0, 1, 32'h0,       32'h0,        6'h1f, 0, 32'h0,        32'hFFFFFFFF, 0);
    step("wrap_c",      1, 0, 0, 1, 32'h0,       32'h0,        6'h1f, 0, 32'h0,        32'd0,        0);
    step("wrap_d",      1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd1,        0);
    step("exc_pre_rst", 1, 0, 0, 1, 32'h1,       32'h0,        6'h00, 1, 32'h20,       32'd1,        0);
    step("rst_in_fl",   0, 0, 0, 1, 32'h1,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    step("rst_in_stl",  0, 0, 0, 1, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    step("rel_run",     1, 0, 0, 0, 32'he,       32'h00001234, 6'h00, 1, 32'h00001234, 32'd0,        0);
    step("rel_flush",   1, 0, 1, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd0,        0);
    step("rel_ex",      1, 0, 1, 0, 32'h0,       32'h0,        6'h0f, 0, 32'h0,        32'd0,        0);
    step("rel_idle",    1, 0, 0, 0, 32'h0,       32'h0,        6'h00, 0, 32'h0,        32'd1,        0);

    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
